serial_tx: RTL and testbench

- Parallel-in, serial-out frame transmitter: the sending end for the team's flip-flop/shift-register serial receiver.
- Accepts a word over a valid/ready handshake and shifts it out on one line, LSB first.
- Frame is start bit (0), data bits, an optional even-parity bit, then a stop bit (1).
- Bit rate is set by a one-cycle enable tick (`en`) from an external divider, so one bit period = one en-qualified clock edge.

---
 rtl/serial_tx.sv | 99 +++++++++
 tb/tb_serial_tx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits LSB first,
// optional even-parity bit, stop bit. One bit per en-qualified clock edge.
module serial_tx #(
   parameter int DATA_W = 8,
   parameter int PARITY = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   input  logic              valid,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(DATA_W) + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]        state;
   logic [DATA_W-1:0] shreg;
   logic [CW-1:0]     cnt;
   logic              par;

   assign busy = ~ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         shreg <= '0;
         cnt   <= '0;
         par   <= 1'b0;
         tx    <= 1'b1;
         ready <= 1'b1;
         done  <= 1'b0;
      end else begin
         // done is a single-cycle pulse, cleared on every edge regardless of en
         done <= 1'b0;
         if (en) begin
            case (state)
               S_IDLE: begin
                  if (valid && ready) begin
                     shreg <= din;
                     par   <= ^din;
                     cnt   <= '0;
                     tx    <= 1'b0;
                     ready <= 1'b0;
                     state <= S_START;
                  end
               end
               S_START: begin
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
                  cnt   <= CW'(1);
                  state <= S_DATA;
               end
               S_DATA: begin
                  // cnt holds the number of data bits already placed on the line
                  if (cnt == CW'(DATA_W)) begin
                     if (PARITY != 0) begin
                        tx    <= par;
                        state <= S_PARITY;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                     end
                  end else begin
                     tx    <= shreg[0];
                     shreg <= shreg >> 1;
                     cnt   <= cnt + CW'(1);
                  end
               end
               S_PARITY: begin
                  tx    <= 1'b1;
                  state <= S_STOP;
               end
               S_STOP: begin
                  tx    <= 1'b1;
                  done  <= 1'b1;
                  ready <= 1'b1;
                  state <= S_IDLE;
               end
               default: begin
                  tx    <= 1'b1;
                  ready <= 1'b1;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance without parity, one with even parity,
// sharing all inputs; expected frames are built from hand-written words.
module tb_serial_tx;

   logic       clk;
   logic       reset;
   logic       en;
   logic [7:0] din;
   logic       valid;
   logic       ready0, tx0, busy0, done0;
   logic       ready1, tx1, busy1, done1;

   int checks   = 0;
   int failures = 0;

   serial_tx #(.DATA_W(8), .PARITY(0)) dut0 (
      .clk(clk), .reset(reset), .en(en), .din(din), .valid(valid),
      .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
   );

   serial_tx #(.DATA_W(8), .PARITY(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .din(din), .valid(valid),
      .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic settle();
      valid = 1'b0;
      en    = 1'b1;
      repeat (14) @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; valid = 1'b0; din = '0;
      #1 reset = 1'b0;
      #1;
      checks++; if (tx0 !== 1'b1)    begin failures++; $display("FAIL reset_tx got=%b exp=1", tx0); end
      checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready0); end
      checks++; if (busy0 !== 1'b0)  begin failures++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      checks++; if (done0 !== 1'b0)  begin failures++; $display("FAIL reset_done got=%b exp=0", done0); end
      checks++; if (tx1 !== 1'b1 || ready1 !== 1'b1) begin failures++; $display("FAIL reset_par tx=%b ready=%b exp=1,1", tx1, ready1); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      en    = 1'b1;
      @(negedge clk);
      checks++; if (ready0 !== 1'b1 || tx0 !== 1'b1) begin failures++; $display("FAIL idle_after_reset ready=%b tx=%b exp=1,1", ready0, tx0); end
   endtask

   task automatic test_basic();
      logic [9:0]  f0;
      logic [10:0] f1;
      f0 = {1'b1, 8'hA5, 1'b0};
      f1 = {1'b1, 1'b0, 8'hA5, 1'b0};
      en = 1'b1; din = 8'hA5; valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 0) valid = 1'b0;
         if (k < 10) begin
            checks++; if (tx0 !== f0[k]) begin failures++; $display("FAIL basic_tx bit=%0d got=%b exp=%b", k, tx0, f0[k]); end
            checks++; if (ready0 !== 1'b0 || busy0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL basic_flags bit=%0d ready=%b busy=%b done=%b exp=0,1,0", k, ready0, busy0, done0); end
         end else if (k == 10) begin
            checks++; if (done0 !== 1'b1 || ready0 !== 1'b1 || tx0 !== 1'b1) begin failures++; $display("FAIL basic_done done=%b ready=%b tx=%b exp=1,1,1", done0, ready0, tx0); end
         end else begin
            checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done0); end
         end
         if (k < 11) begin
            checks++; if (tx1 !== f1[k]) begin failures++; $display("FAIL basic_par_tx bit=%0d got=%b exp=%b", k, tx1, f1[k]); end
         end else begin
            checks++; if (done1 !== 1'b1) begin failures++; $display("FAIL basic_par_done got=%b exp=1", done1); end
         end
      end
      settle();
   endtask

   task automatic test_parity();
      logic [10:0] f1;
      f1 = {1'b1, 1'b1, 8'h07, 1'b0};
      en = 1'b1; din = 8'h07; valid = 1'b1;
      for (int k = 0; k < 13; k++) begin
         @(negedge clk);
         if (k == 0) valid = 1'b0;
         if (k < 11) begin
            checks++; if (tx1 !== f1[k]) begin failures++; $display("FAIL parity_tx bit=%0d got=%b exp=%b", k, tx1, f1[k]); end
            checks++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin failures++; $display("FAIL parity_flags bit=%0d busy=%b done=%b exp=1,0", k, busy1, done1); end
         end else if (k == 11) begin
            checks++; if (done1 !== 1'b1 || ready1 !== 1'b1) begin failures++; $display("FAIL parity_done done=%b ready=%b exp=1,1", done1, ready1); end
         end else begin
            checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL parity_done_pulse got=%b exp=0", done1); end
         end
      end
      settle();
   endtask

   task automatic test_enable();
      logic [9:0] f0;
      f0 = {1'b1, 8'h3C, 1'b0};
      @(negedge clk);
      en = 1'b0; valid = 1'b1; din = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (ready0 !== 1'b1 || tx0 !== 1'b1) begin failures++; $display("FAIL enable_holdoff cyc=%0d ready=%b tx=%b exp=1,1", i, ready0, tx0); end
      end
      en = 1'b1;
      @(negedge clk);
      for (int j = 0; j < 42; j++) begin
         if (j > 0) @(negedge clk);
         if (j == 0) valid = 1'b0;
         if (j < 40) begin
            checks++; if (tx0 !== f0[j/4]) begin failures++; $display("FAIL enable_tx clk=%0d got=%b exp=%b", j, tx0, f0[j/4]); end
            checks++; if (ready0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL enable_flags clk=%0d ready=%b done=%b exp=0,0", j, ready0, done0); end
         end else if (j == 40) begin
            checks++; if (done0 !== 1'b1 || ready0 !== 1'b1) begin failures++; $display("FAIL enable_done done=%b ready=%b exp=1,1", done0, ready0); end
         end else begin
            checks++; if (done0 !== 1'b0) begin failures++; $display("FAIL enable_done_clear got=%b exp=0", done0); end
         end
         en = ((j % 4) == 3);
      end
      settle();
   endtask

   task automatic test_busy_ignore();
      logic [9:0] f0;
      f0 = {1'b1, 8'h96, 1'b0};
      en = 1'b1; din = 8'h96; valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (k < 10) begin
            checks++; if (tx0 !== f0[k]) begin failures++; $display("FAIL busy_tx bit=%0d got=%b exp=%b", k, tx0, f0[k]); end
         end else if (k == 10) begin
            checks++; if (done0 !== 1'b1 || ready0 !== 1'b1) begin failures++; $display("FAIL busy_done done=%b ready=%b exp=1,1", done0, ready0); end
         end else begin
            checks++; if (tx0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL busy_no_second k=%0d tx=%b ready=%b done=%b exp=1,1,0", k, tx0, ready0, done0); end
         end
         if (k == 0) valid = 1'b0;
         if (k >= 2 && k <= 4) begin valid = 1'b1; din = 8'hFF; end
         if (k == 5) valid = 1'b0;
      end
      settle();
   endtask

   task automatic test_reset_mid();
      logic [9:0] fa;
      logic [9:0] fb;
      fa = {1'b1, 8'hC3, 1'b0};
      fb = {1'b1, 8'h5A, 1'b0};
      en = 1'b1; din = 8'hC3; valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) valid = 1'b0;
         checks++; if (tx0 !== fa[k]) begin failures++; $display("FAIL rstmid_pre_tx bit=%0d got=%b exp=%b", k, tx0, fa[k]); end
      end
      #2 reset = 1'b0;
      #1;
      checks++; if (tx0 !== 1'b1)    begin failures++; $display("FAIL rstmid_tx got=%b exp=1", tx0); end
      checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready0); end
      checks++; if (busy0 !== 1'b0)  begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy0); end
      checks++; if (done0 !== 1'b0)  begin failures++; $display("FAIL rstmid_done got=%b exp=0", done0); end
      @(negedge clk);
      reset = 1'b1; din = 8'h5A; valid = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 0) valid = 1'b0;
         if (k < 10) begin
            checks++; if (tx0 !== fb[k]) begin failures++; $display("FAIL rstmid_post_tx bit=%0d got=%b exp=%b", k, tx0, fb[k]); end
         end else if (k == 10) begin
            checks++; if (done0 !== 1'b1 || ready0 !== 1'b1) begin failures++; $display("FAIL rstmid_post_done done=%b ready=%b exp=1,1", done0, ready0); end
         end
      end
      settle();
   endtask

   task automatic test_back_to_back();
      logic [9:0] fa;
      logic [9:0] fb;
      int         dones;
      fa = {1'b1, 8'h01, 1'b0};
      fb = {1'b1, 8'h80, 1'b0};
      dones = 0;
      en = 1'b1; din = 8'h01; valid = 1'b1;
      for (int k = 0; k < 23; k++) begin
         @(negedge clk);
         if (done0 === 1'b1) dones++;
         if (k < 10) begin
            checks++; if (tx0 !== fa[k]) begin failures++; $display("FAIL b2b_first_tx bit=%0d got=%b exp=%b", k, tx0, fa[k]); end
         end else if (k == 10) begin
            checks++; if (tx0 !== 1'b1 || ready0 !== 1'b1 || done0 !== 1'b1) begin failures++; $display("FAIL b2b_gap tx=%b ready=%b done=%b exp=1,1,1", tx0, ready0, done0); end
         end else if (k < 21) begin
            checks++; if (tx0 !== fb[k-11]) begin failures++; $display("FAIL b2b_second_tx bit=%0d got=%b exp=%b", k-11, tx0, fb[k-11]); end
         end else if (k == 21) begin
            checks++; if (done0 !== 1'b1 || ready0 !== 1'b1) begin failures++; $display("FAIL b2b_second_done done=%b ready=%b exp=1,1", done0, ready0); end
         end
         if (k == 0) din = 8'h80;
         if (k == 11) valid = 1'b0;
      end
      checks++; if (dones != 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
      settle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_enable();
      test_busy_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
